lbist_seq_controller: RTL and testbench
=======================================

LBIST_SEQ_CONTROLLER -- requirements
Module: lbist_seq_controller

Interface
REQ-001 Parameter SETUP_CYCLES, default 10: cycles for which the CUT and TPG are held in reset before each run; legal range is 1 or more.
REQ-002 Parameter N_SESSIONS, default 4: number of test sessions (seeds) per run; legal range is 1 or more.
REQ-003 Parameter EVAL_TIMEOUT, default 16: maximum cycles spent in EVAL waiting for ORA_RES; legal range is 1 or more.
REQ-004 Parameter STOP_ON_FAIL, default 0: when 1, the first failing session ends the run.
REQ-005 Derived width: SW = max(1, clog2(N_SESSIONS)).
REQ-006 Port: clk, input, 1: sole clock; all state changes on the rising edge.
REQ-007 Port: RESET, input, 1: asynchronous, active-high reset.
REQ-008 Port: START, input, 1: run request; sampled in IDLE and DONE only.
REQ-009 Port: TPG_END, input, 1: TPG has exhausted its patterns for the current session.
REQ-010 Port: ORA_RES, input, 1: ORA signature-compare result valid, single cycle.
REQ-011 Port: ORA_FAIL, input, 1: signature mismatch; qualified by ORA_RES.
REQ-012 Port: CUT_RESET, output, 1: reset to the circuit under test.
REQ-013 Port: TPG_RESET, output, 1: TPG reseed/reset.
REQ-014 Port: INC, output, 1: single-cycle pulse that advances the seed/session pointer.
REQ-015 Port: SESSION, output, SW: index of the current session.
REQ-016 Port: BUSY, output, 1: high in SETUP, RUN, EVAL and NEXT.
REQ-017 Port: DONE, output, 1: high in DONE.
REQ-018 Port: PASS, output, 1: valid while DONE is high; 1 when no session failed.
REQ-019 Port: FAIL_CNT, output, SW+1: number of failing sessions; saturates at its all-ones value.

Function
REQ-020 States: IDLE, SETUP, RUN, EVAL, NEXT, DONE. All outputs are registered.
REQ-021 IDLE: CUT_RESET=1, TPG_RESET=1; START=1 moves to SETUP and clears SESSION, FAIL_CNT and PASS.
REQ-022 SETUP: CUT_RESET=1 and TPG_RESET=1 for exactly SETUP_CYCLES cycles, then move to RUN.
REQ-023 RUN: CUT_RESET=0, TPG_RESET=0; TPG_END=1 moves to EVAL and clears the timeout counter; ORA_RES alone in RUN is ignored.
REQ-024 If TPG_END and ORA_RES are both 1 in the same RUN cycle, the result is consumed immediately and the state moves to NEXT, skipping EVAL.
REQ-025 EVAL: ORA_RES=1 consumes the result and moves to NEXT.
REQ-026 EVAL timeout: after EVAL_TIMEOUT cycles without ORA_RES, the session counts as failed and the state moves to NEXT.
REQ-027 A consumed result with ORA_FAIL=1, or a timeout, increments FAIL_CNT (saturating).
REQ-028 NEXT lasts 1 cycle with INC=1 and TPG_RESET=1; CUT_RESET stays 0.
REQ-029 NEXT exit: if SESSION==N_SESSIONS-1, or if STOP_ON_FAIL=1 and FAIL_CNT!=0, move to DONE; otherwise increment SESSION and move to RUN.
REQ-030 SESSION never exceeds N_SESSIONS-1 and never wraps within a run.
REQ-031 DONE: DONE=1, PASS=(FAIL_CNT==0), CUT_RESET=0, TPG_RESET=1; START=1 behaves exactly as START in IDLE (restart).
REQ-032 START is ignored while BUSY=1.
REQ-033 INC is high only in NEXT, and every NEXT produces exactly one INC pulse.

Reset
REQ-034 RESET=1 forces, immediately and asynchronously: state=IDLE, CUT_RESET=1, TPG_RESET=1, INC=0, BUSY=0, DONE=0, PASS=0, SESSION=0, FAIL_CNT=0.
REQ-035 RESET asserted mid-run aborts the run with no further INC pulse; after release the block waits in IDLE for START.

Verification
REQ-036 Defaults, START pulse, each session gives TPG_END followed 3 cycles later by ORA_RES with ORA_FAIL=0 -> 10 SETUP cycles, 4 INC pulses, SESSION steps 0..3, then DONE=1, PASS=1, FAIL_CNT=0.
REQ-037 Defaults, session 1 returns ORA_FAIL=1 -> all 4 sessions run, FAIL_CNT=1, PASS=0; with STOP_ON_FAIL=1 -> DONE after the 2nd INC with SESSION=1.
REQ-038 TPG_END with no ORA_RES -> NEXT entered exactly 16 cycles after EVAL entry, and FAIL_CNT increments.
REQ-039 TPG_END and ORA_RES in the same cycle -> INC on the next cycle, with no EVAL cycle.
REQ-040 RESET pulsed during RUN of session 2 -> all outputs at reset values in the same cycle; a later START restarts from SESSION=0.
REQ-041 START held high for 50 cycles -> exactly one run; START asserted in DONE -> second run with FAIL_CNT cleared.

Source files
------------

// File: rtl/lbist_seq_controller.sv
// LBIST sequencer: holds the CUT and TPG in reset for a setup period, then
// steps through N_SESSIONS seeded sessions, waits for each ORA verdict (with
// a timeout), counts failing sessions and reports PASS once the run is done.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for START; CUT and TPG held in reset
// ST_SETUP | CUT and TPG held in reset for SETUP_CYCLES cycles
// ST_RUN   | TPG applying patterns for the current session
// ST_EVAL  | waiting up to EVAL_TIMEOUT cycles for the ORA verdict
// ST_NEXT  | one-cycle INC pulse, TPG reseeded, pick next session or finish
// ST_DONE  | run finished, PASS valid; START restarts
module lbist_seq_controller #(
  parameter int SETUP_CYCLES = 10,
  parameter int N_SESSIONS   = 4,
  parameter int EVAL_TIMEOUT = 16,
  parameter bit STOP_ON_FAIL = 1'b0,
  localparam int SW = (N_SESSIONS > 1) ? $clog2(N_SESSIONS) : 1
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          START,
  input  logic          TPG_END,
  input  logic          ORA_RES,
  input  logic          ORA_FAIL,
  output logic          CUT_RESET,
  output logic          TPG_RESET,
  output logic          INC,
  output logic [SW-1:0] SESSION,
  output logic          BUSY,
  output logic          DONE,
  output logic          PASS,
  output logic [SW:0]   FAIL_CNT
);

  // Down-counter widths: each must hold its load value (count - 1).
  localparam int SCW = (SETUP_CYCLES > 2) ? $clog2(SETUP_CYCLES) : 1;
  localparam int ECW = (EVAL_TIMEOUT > 2) ? $clog2(EVAL_TIMEOUT) : 1;

  localparam logic [SCW-1:0] SETUP_LOAD = SCW'(SETUP_CYCLES - 1);
  localparam logic [ECW-1:0] TMO_LOAD   = ECW'(EVAL_TIMEOUT - 1);
  localparam logic [SW-1:0]  LAST_SESS  = SW'(N_SESSIONS - 1);
  localparam logic [SW:0]    FAIL_MAX   = {(SW + 1){1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_RUN   = 3'd2,
    ST_EVAL  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [SCW-1:0] setup_cnt_q, setup_cnt_d;
  logic [ECW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [SW-1:0]  session_q, session_d;
  logic [SW:0]    fail_cnt_q, fail_cnt_d;
  logic           sess_fail;

  logic cut_reset_d, tpg_reset_d, inc_d, busy_d, done_d, pass_d;
  logic cut_reset_q, tpg_reset_q, inc_q, busy_q, done_q, pass_q;

  // State, counters and registered outputs; reset puts everything in IDLE.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      setup_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      session_q   <= '0;
      fail_cnt_q  <= '0;
      cut_reset_q <= 1'b1;
      tpg_reset_q <= 1'b1;
      inc_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      session_q   <= session_d;
      fail_cnt_q  <= fail_cnt_d;
      cut_reset_q <= cut_reset_d;
      tpg_reset_q <= tpg_reset_d;
      inc_q       <= inc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  // Next-state logic: sequencing, timers, session pointer and fail counting.
  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    session_d   = session_q;
    fail_cnt_d  = fail_cnt_q;
    sess_fail   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d     = ST_SETUP;
          setup_cnt_d = SETUP_LOAD;
          session_d   = '0;
          fail_cnt_d  = '0;
        end
      end

      ST_SETUP: begin
        if (setup_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          setup_cnt_d = setup_cnt_q - 1'b1;
        end
      end

      ST_RUN: begin
        // A verdict arriving with TPG_END is consumed at once, skipping EVAL.
        if (TPG_END) begin
          if (ORA_RES) begin
            state_d   = ST_NEXT;
            sess_fail = ORA_FAIL;
          end else begin
            state_d   = ST_EVAL;
            tmo_cnt_d = TMO_LOAD;
          end
        end
      end

      ST_EVAL: begin
        // A verdict on the last allowed cycle still wins over the timeout.
        if (ORA_RES) begin
          state_d   = ST_NEXT;
          sess_fail = ORA_FAIL;
        end else if (tmo_cnt_q == '0) begin
          state_d   = ST_NEXT;
          sess_fail = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
      end

      ST_NEXT: begin
        if ((session_q == LAST_SESS) || (STOP_ON_FAIL && (fail_cnt_q != '0))) begin
          state_d = ST_DONE;
        end else begin
          state_d   = ST_RUN;
          session_d = session_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (sess_fail && (fail_cnt_q != FAIL_MAX)) begin
      fail_cnt_d = fail_cnt_q + 1'b1;
    end
  end

  // Output decode from the upcoming state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    cut_reset_d = 1'b0;
    tpg_reset_d = 1'b0;
    inc_d       = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    pass_d      = 1'b0;

    case (state_d)
      ST_IDLE: begin
        cut_reset_d = 1'b1;
        tpg_reset_d = 1'b1;
      end
      ST_SETUP: begin
        cut_reset_d = 1'b1;
        tpg_reset_d = 1'b1;
        busy_d      = 1'b1;
      end
      ST_RUN, ST_EVAL: begin
        busy_d = 1'b1;
      end
      ST_NEXT: begin
        tpg_reset_d = 1'b1;
        inc_d       = 1'b1;
        busy_d      = 1'b1;
      end
      ST_DONE: begin
        tpg_reset_d = 1'b1;
        done_d      = 1'b1;
        pass_d      = (fail_cnt_d == '0);
      end
      default: begin
        cut_reset_d = 1'b1;
        tpg_reset_d = 1'b1;
      end
    endcase
  end

  assign CUT_RESET = cut_reset_q;
  assign TPG_RESET = tpg_reset_q;
  assign INC       = inc_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign SESSION   = session_q;
  assign FAIL_CNT  = fail_cnt_q;

endmodule

// File: tb/tb_lbist_seq_controller.sv
// Bench for lbist_seq_controller: builds an expected per-cycle timeline from
// the sequencing rules (setup length, session flow, timeout, fail counting),
// replays its inputs into two DUTs (STOP_ON_FAIL 0 and 1) and compares every
// output every cycle, plus literal checks at the end of directed runs.
module tb_lbist_seq_controller;

  localparam int SETUP = 10;
  localparam int NS    = 4;
  localparam int TMO   = 16;
  localparam int FMAX  = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_v   = 2'b00;
  logic [1:0] start_v = 2'b00;
  logic [1:0] tend_v  = 2'b00;
  logic [1:0] ores_v  = 2'b00;
  logic [1:0] ofail_v = 2'b00;
  logic [1:0] cut_o, tpg_o, inc_o, busy_o, done_o, pass_o;
  logic [1:0] sess_o [2];
  logic [2:0] fcnt_o [2];

  lbist_seq_controller #(.SETUP_CYCLES(SETUP), .N_SESSIONS(NS), .EVAL_TIMEOUT(TMO),
                         .STOP_ON_FAIL(1'b0)) u_dut0 (
    .clk(clk), .RESET(rst_v[0]), .START(start_v[0]), .TPG_END(tend_v[0]),
    .ORA_RES(ores_v[0]), .ORA_FAIL(ofail_v[0]), .CUT_RESET(cut_o[0]),
    .TPG_RESET(tpg_o[0]), .INC(inc_o[0]), .SESSION(sess_o[0]), .BUSY(busy_o[0]),
    .DONE(done_o[0]), .PASS(pass_o[0]), .FAIL_CNT(fcnt_o[0]));

  lbist_seq_controller #(.SETUP_CYCLES(SETUP), .N_SESSIONS(NS), .EVAL_TIMEOUT(TMO),
                         .STOP_ON_FAIL(1'b1)) u_dut1 (
    .clk(clk), .RESET(rst_v[1]), .START(start_v[1]), .TPG_END(tend_v[1]),
    .ORA_RES(ores_v[1]), .ORA_FAIL(ofail_v[1]), .CUT_RESET(cut_o[1]),
    .TPG_RESET(tpg_o[1]), .INC(inc_o[1]), .SESSION(sess_o[1]), .BUSY(busy_o[1]),
    .DONE(done_o[1]), .PASS(pass_o[1]), .FAIL_CNT(fcnt_o[1]));

  typedef struct {
    int d;
    bit rst, start, tpg_end, ora_res, ora_fail;
    bit e_cut, e_tpg, e_inc, e_busy, e_done, e_pass;
    int e_sess, e_fail;
    bit mark;
    bit lit_en, lit_pass;
    int lit_sess, lit_fail, lit_incs;
  } vec_t;

  typedef struct {
    int run_len;
    bit same;
    int eval_d;
    bit tmo;
    bit fail;
  } sess_t;

  vec_t  tl[$];
  sess_t sps[NS];
  int    m_mode[2];
  int    m_sess[2];
  int    m_fail[2];
  int    held;

  int n_cmp = 0;
  int n_bad = 0;
  int cur = 0;
  bit active = 1'b0;
  int inc_cnt[2];
  int setup_cnt[2];

  function automatic bit rb();
    return ($urandom_range(0, 1) == 1);
  endfunction

  function automatic vec_t base(int d);
    vec_t v;
    v = '{default: 0};
    v.d        = d;
    v.tpg_end  = rb();
    v.ora_res  = rb();
    v.ora_fail = rb();
    v.e_sess   = m_sess[d];
    v.e_fail   = m_fail[d];
    return v;
  endfunction

  // Quiescent cycle in IDLE (mode 0) or DONE (mode 1); START low.
  function automatic vec_t quiet(int d);
    vec_t v;
    v = base(d);
    if (m_mode[d] == 0) begin
      v.e_cut = 1'b1;
      v.e_tpg = 1'b1;
    end else begin
      v.e_tpg  = 1'b1;
      v.e_done = 1'b1;
      v.e_pass = (m_fail[d] == 0);
    end
    return v;
  endfunction

  // Busy cycle; START is held while 'held' lasts, otherwise random noise.
  function automatic vec_t busy_vec(int d, bit cut, bit tpg, bit inc);
    vec_t v;
    v = base(d);
    v.e_busy = 1'b1;
    v.e_cut  = cut;
    v.e_tpg  = tpg;
    v.e_inc  = inc;
    if (held > 0) begin
      v.start = 1'b1;
      held--;
    end else begin
      v.start = ($urandom_range(0, 3) == 0);
    end
    return v;
  endfunction

  function automatic void set_sess(int s, int rl, bit same, int ed, bit tmo, bit fl);
    sps[s].run_len = rl;
    sps[s].same    = same;
    sps[s].eval_d  = ed;
    sps[s].tmo     = tmo;
    sps[s].fail    = fl;
  endfunction

  function automatic void set_all(int rl, bit same, int ed, bit tmo, bit fl);
    for (int s = 0; s < NS; s++) set_sess(s, rl, same, ed, tmo, fl);
  endfunction

  function automatic void rand_sess();
    for (int s = 0; s < NS; s++) begin
      sps[s].run_len = $urandom_range(1, 8);
      sps[s].same    = ($urandom_range(0, 3) == 0);
      sps[s].tmo     = !sps[s].same && ($urandom_range(0, 7) == 0);
      sps[s].eval_d  = $urandom_range(0, TMO - 1);
      sps[s].fail    = ($urandom_range(0, 3) == 0);
    end
  endfunction

  task automatic add_quiet(input int d, input int n);
    for (int i = 0; i < n; i++) tl.push_back(quiet(d));
  endtask

  task automatic add_reset(input int d);
    vec_t v;
    m_mode[d] = 0;
    m_sess[d] = 0;
    m_fail[d] = 0;
    v = quiet(d);
    v.rst   = 1'b1;
    v.start = rb();
    tl.push_back(v);
  endtask

  // One run from IDLE/DONE using the session plan in sps[]; optionally aborted
  // by RESET at RUN cycle abort_k of session abort_s.
  task automatic add_run(input int d, input int start_len, input int abort_s, input int abort_k,
                         input bit lit_en, input int l_sess, input int l_fail, input bit l_pass,
                         input int l_incs);
    vec_t v;
    bit failed;
    bit stop;
    stop = (d == 1);
    v = quiet(d);
    v.start = 1'b1;
    v.mark  = 1'b1;
    tl.push_back(v);
    m_sess[d] = 0;
    m_fail[d] = 0;
    held = start_len - 1;
    for (int i = 0; i < SETUP; i++) tl.push_back(busy_vec(d, 1'b1, 1'b1, 1'b0));
    for (int s = 0; s < NS; s++) begin
      m_sess[d] = s;
      for (int i = 0; i < sps[s].run_len; i++) begin
        if (s == abort_s && i == abort_k) begin
          add_reset(d);
          return;
        end
        v = busy_vec(d, 1'b0, 1'b0, 1'b0);
        if (i == sps[s].run_len - 1) begin
          v.tpg_end = 1'b1;
          v.ora_res = sps[s].same;
          if (sps[s].same) v.ora_fail = sps[s].fail;
        end else begin
          v.tpg_end = 1'b0;
        end
        tl.push_back(v);
      end
      if (sps[s].same) begin
        failed = sps[s].fail;
      end else if (sps[s].tmo) begin
        for (int i = 0; i < TMO; i++) begin
          v = busy_vec(d, 1'b0, 1'b0, 1'b0);
          v.ora_res = 1'b0;
          tl.push_back(v);
        end
        failed = 1'b1;
      end else begin
        for (int i = 0; i < sps[s].eval_d; i++) begin
          v = busy_vec(d, 1'b0, 1'b0, 1'b0);
          v.ora_res = 1'b0;
          tl.push_back(v);
        end
        v = busy_vec(d, 1'b0, 1'b0, 1'b0);
        v.ora_res  = 1'b1;
        v.ora_fail = sps[s].fail;
        tl.push_back(v);
        failed = sps[s].fail;
      end
      if (failed) m_fail[d] = (m_fail[d] < FMAX) ? m_fail[d] + 1 : FMAX;
      tl.push_back(busy_vec(d, 1'b0, 1'b1, 1'b1));
      if (s == NS - 1 || (stop && m_fail[d] != 0)) break;
    end
    m_mode[d] = 1;
    v = quiet(d);
    v.lit_en   = lit_en;
    v.lit_sess = l_sess;
    v.lit_fail = l_fail;
    v.lit_pass = l_pass;
    v.lit_incs = l_incs;
    tl.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    start_v = 2'b00;
    tend_v  = 2'b00;
    ores_v  = 2'b00;
    ofail_v = 2'b00;
    rst_v[v.d]   = v.rst;
    start_v[v.d] = v.start;
    tend_v[v.d]  = v.tpg_end;
    ores_v[v.d]  = v.ora_res;
    ofail_v[v.d] = v.ora_fail;
  endtask

  task automatic chk(input string nm, input int d, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s entry=%0d dut=%0d got=%0d want=%0d", nm, cur, d, act, exp);
    end
  endtask

  // Compare process: every replayed cycle, all outputs of the selected DUT.
  always @(negedge clk) begin
    vec_t v;
    int d;
    if (active) begin
      v = tl[cur];
      d = v.d;
      if (v.mark) begin
        inc_cnt[d]   = 0;
        setup_cnt[d] = 0;
      end
      chk("CUT_RESET", d, int'(cut_o[d]),  int'(v.e_cut));
      chk("TPG_RESET", d, int'(tpg_o[d]),  int'(v.e_tpg));
      chk("INC",       d, int'(inc_o[d]),  int'(v.e_inc));
      chk("BUSY",      d, int'(busy_o[d]), int'(v.e_busy));
      chk("DONE",      d, int'(done_o[d]), int'(v.e_done));
      chk("PASS",      d, int'(pass_o[d]), int'(v.e_pass));
      chk("SESSION",   d, int'(sess_o[d]), v.e_sess);
      chk("FAIL_CNT",  d, int'(fcnt_o[d]), v.e_fail);
      if (inc_o[d]) inc_cnt[d]++;
      if (busy_o[d] && cut_o[d]) setup_cnt[d]++;
      if (v.lit_en) begin
        chk("PIN_SESSION",  d, int'(sess_o[d]), v.lit_sess);
        chk("PIN_FAIL_CNT", d, int'(fcnt_o[d]), v.lit_fail);
        chk("PIN_PASS",     d, int'(pass_o[d]), int'(v.lit_pass));
        chk("PIN_INC_COUNT",   d, inc_cnt[d], v.lit_incs);
        chk("PIN_SETUP_COUNT", d, setup_cnt[d], 10);
      end
    end
  end

  initial begin
    int s, k;
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_sess[i] = 0; m_fail[i] = 0;
      inc_cnt[i] = 0; setup_cnt[i] = 0;
    end
    held = 0;

    // Instance without STOP_ON_FAIL.
    add_reset(0);
    add_quiet(0, 3);
    set_all(4, 0, 2, 0, 0);
    add_run(0, 1, -1, 0, 1'b1, 3, 0, 1'b1, 4);
    add_quiet(0, 3);
    set_all(4, 0, 2, 0, 0);
    set_sess(1, 4, 0, 2, 0, 1);
    add_run(0, 1, -1, 0, 1'b1, 3, 1, 1'b0, 4);
    add_quiet(0, 2);
    set_all(10, 0, 2, 0, 0);
    add_run(0, 50, -1, 0, 1'b1, 3, 0, 1'b1, 4);
    add_quiet(0, 5);
    set_all(3, 0, 5, 0, 0);
    set_sess(0, 3, 0, 0, 1, 0);
    add_run(0, 1, -1, 0, 1'b1, 3, 1, 1'b0, 4);
    set_all(2, 1, 0, 0, 0);
    set_sess(2, 2, 1, 0, 0, 1);
    add_run(0, 1, -1, 0, 1'b1, 3, 1, 1'b0, 4);
    set_all(3, 0, 1, 0, 1);
    add_run(0, 2, -1, 0, 1'b1, 3, 4, 1'b0, 4);
    set_all(6, 0, 2, 0, 0);
    add_run(0, 1, 2, 3, 1'b0, 0, 0, 1'b0, 0);
    add_quiet(0, 3);
    add_run(0, 1, -1, 0, 1'b1, 3, 0, 1'b1, 4);
    for (int r = 0; r < 15; r++) begin
      rand_sess();
      if ($urandom_range(0, 4) == 0) begin
        s = $urandom_range(0, NS - 1);
        k = $urandom_range(0, sps[s].run_len - 1);
        add_run(0, $urandom_range(1, 3), s, k, 1'b0, 0, 0, 1'b0, 0);
      end else begin
        add_run(0, $urandom_range(1, 3), -1, 0, 1'b0, 0, 0, 1'b0, 0);
      end
      add_quiet(0, $urandom_range(0, 3));
    end

    // Instance with STOP_ON_FAIL.
    add_reset(1);
    add_quiet(1, 2);
    set_all(4, 0, 2, 0, 0);
    set_sess(1, 4, 0, 2, 0, 1);
    add_run(1, 1, -1, 0, 1'b1, 1, 1, 1'b0, 2);
    add_quiet(1, 2);
    set_all(4, 0, 2, 0, 0);
    add_run(1, 1, -1, 0, 1'b1, 3, 0, 1'b1, 4);
    for (int r = 0; r < 10; r++) begin
      rand_sess();
      add_run(1, $urandom_range(1, 3), -1, 0, 1'b0, 0, 0, 1'b0, 0);
      add_quiet(1, $urandom_range(0, 3));
    end

    cur = 0;
    apply(tl[0]);
    active = 1'b1;
    for (int i = 1; i < tl.size(); i++) begin
      @(posedge clk);
      #1;
      cur = i;
      apply(tl[i]);
    end
    @(posedge clk);
    #1;
    active = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
